// File: rtl/bullet_pkg.sv
// Shared types and helpers for the bullet engine: coordinate width, RGB type,
// direction encoding and the clamped x-advance rule.
package bullet_pkg;

    localparam int COORD_W = 12;
    localparam int EXT_W   = COORD_W + 1;

    typedef logic [23:0] rgb_t;

    localparam rgb_t COLOR_BLACK  = 24'h000000;
    localparam rgb_t COLOR_BULLET = 24'h171E1A;

    typedef enum logic {
        DIR_DEC = 1'b0,
        DIR_INC = 1'b1
    } dir_e;

    // Move x by step toward x_end without ever passing it; sums use one extra
    // bit so neither direction can wrap.
    function automatic logic [COORD_W-1:0] advance_x(
        input logic [COORD_W-1:0] x,
        input dir_e               dir,
        input logic [COORD_W-1:0] step,
        input logic [COORD_W-1:0] x_end
    );
        logic [COORD_W-1:0] result;
        if (dir == DIR_DEC) begin
            if ({1'b0, x} < ({1'b0, x_end} + {1'b0, step}))
                result = x_end;
            else
                result = x - step;
        end else begin
            if (({1'b0, x} + {1'b0, step}) > {1'b0, x_end})
                result = x_end;
            else
                result = x + step;
        end
        return result;
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One projectile slot: position/live state, per-step motion with retire at the
// terminal x, and the rectangle hit test against the delayed scan position.
module bullet_slot
    import bullet_pkg::*;
#(
    parameter int DIR        = 0,
    parameter int FIG_X0     = 715,
    parameter int X_END      = 60,
    parameter int STEP       = 1,
    parameter int FIG_WIDTH  = 27,
    parameter int FIG_HEIGHT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               spawn,
    input  logic               step,
    input  logic               collision,
    input  logic [COORD_W-1:0] spawn_y,
    input  logic [COORD_W-1:0] lcd_x,
    input  logic [COORD_W-1:0] lcd_y,
    output logic               active,
    output logic               hit
);

    localparam logic [COORD_W-1:0] X0_C     = COORD_W'(FIG_X0);
    localparam logic [COORD_W-1:0] X_END_C  = COORD_W'(X_END);
    localparam logic [COORD_W-1:0] STEP_C   = COORD_W'(STEP);
    localparam logic [EXT_W-1:0]   WIDTH_C  = EXT_W'(FIG_WIDTH);
    localparam logic [EXT_W-1:0]   HEIGHT_C = EXT_W'(FIG_HEIGHT);
    localparam dir_e               DIR_C    = (DIR != 0) ? DIR_INC : DIR_DEC;

    logic [COORD_W-1:0] x_reg;
    logic [COORD_W-1:0] y_reg;
    logic               active_reg;

    // A hit overrides motion; spawning only ever targets an idle slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg      <= X0_C;
            y_reg      <= '0;
            active_reg <= 1'b0;
        end else if (clear) begin
            x_reg      <= X0_C;
            y_reg      <= '0;
            active_reg <= 1'b0;
        end else if (collision && active_reg) begin
            x_reg      <= X0_C;
            active_reg <= 1'b0;
        end else if (active_reg && step) begin
            if (x_reg == X_END_C) begin
                x_reg      <= X0_C;
                active_reg <= 1'b0;
            end else begin
                x_reg <= advance_x(x_reg, DIR_C, STEP_C, X_END_C);
            end
        end else if (spawn && !active_reg) begin
            x_reg      <= X0_C;
            y_reg      <= spawn_y;
            active_reg <= 1'b1;
        end
    end

    logic in_x;
    logic in_y;

    assign in_x   = ({1'b0, x_reg} <= {1'b0, lcd_x}) &&
                    ({1'b0, lcd_x} <  ({1'b0, x_reg} + WIDTH_C));
    assign in_y   = ({1'b0, y_reg} <= {1'b0, lcd_y}) &&
                    ({1'b0, lcd_y} <  ({1'b0, y_reg} + HEIGHT_C));
    assign hit    = active_reg && in_x && in_y;
    assign active = active_reg;

endmodule

// File: rtl/multi_bullet_pixel_mod.sv
// Bullet engine top: shot cooldown, animation frame divider, lowest-free-slot
// spawn encoder, slot array and the registered bullet pixel layer.
module multi_bullet_pixel_mod
    import bullet_pkg::*;
#(
    parameter int   N_SLOTS     = 3,
    parameter int   DIR         = 0,
    parameter int   FIG_X0      = 715,
    parameter int   X_END       = 60,
    parameter int   STEP        = 1,
    parameter int   Y_OFFSET    = 9,
    parameter int   FIG_WIDTH   = 27,
    parameter int   FIG_HEIGHT  = 4,
    parameter int   ANIM_FRAMES = 1,
    parameter int   MIN_WAIT    = 30000000,
    parameter rgb_t COLOR       = COLOR_BULLET
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] lcd_xpos,
    input  logic [COORD_W-1:0] lcd_ypos,
    input  logic [COORD_W-1:0] y_pos,
    input  logic               enable,
    input  logic               shoot,
    input  logic               freeze,
    input  logic [N_SLOTS-1:0] collision,
    output rgb_t               bullet_pixel,
    output logic               pixel_valid,
    output logic [N_SLOTS-1:0] slot_active
);

    localparam int CD_W = (MIN_WAIT < 1) ? 1 : $clog2(MIN_WAIT + 1);
    localparam int FC_W = (ANIM_FRAMES <= 1) ? 1 : $clog2(ANIM_FRAMES);
    localparam logic [CD_W-1:0]    CD_MAX  = CD_W'(MIN_WAIT);
    localparam logic [FC_W-1:0]    FC_LAST = FC_W'(ANIM_FRAMES - 1);
    localparam logic [COORD_W-1:0] Y_OFF_C = COORD_W'(Y_OFFSET);

    logic [CD_W-1:0]    cd_reg;
    logic [FC_W-1:0]    fc_reg;
    logic [COORD_W-1:0] lcd_x_reg;
    logic [COORD_W-1:0] lcd_y_reg;
    logic               valid_reg;
    rgb_t               pixel_reg;

    logic               frame_tick;
    logic               cd_ready;
    logic               step_pulse;
    logic               spawn_fire;
    logic [N_SLOTS-1:0] active_vec;
    logic [N_SLOTS-1:0] free_vec;
    logic [N_SLOTS-1:0] lowest_free;
    logic [N_SLOTS-1:0] spawn_vec;
    logic [N_SLOTS-1:0] hit_vec;
    logic [COORD_W-1:0] spawn_y;

    assign frame_tick = (lcd_xpos == '0) && (lcd_ypos == '0);
    assign cd_ready   = (cd_reg == CD_MAX);
    assign step_pulse = frame_tick && !freeze && (fc_reg == FC_LAST);
    assign spawn_y    = y_pos + Y_OFF_C;

    // Free mask comes from current state, so a slot retiring this cycle is
    // still seen as busy; x & -x isolates the lowest free index.
    assign free_vec    = ~active_vec;
    assign lowest_free = free_vec & (~free_vec + 1'b1);
    assign spawn_fire  = enable && shoot && cd_ready && !freeze && (|free_vec);
    assign spawn_vec   = spawn_fire ? lowest_free : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cd_reg <= '0;
        end else if (!enable || spawn_fire) begin
            cd_reg <= '0;
        end else if (!cd_ready) begin
            cd_reg <= cd_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fc_reg <= '0;
        end else if (!enable || freeze) begin
            fc_reg <= '0;
        end else if (frame_tick) begin
            if (fc_reg == FC_LAST)
                fc_reg <= '0;
            else
                fc_reg <= fc_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_SLOTS; gi++) begin : g_slot
            bullet_slot #(
                .DIR        (DIR),
                .FIG_X0     (FIG_X0),
                .X_END      (X_END),
                .STEP       (STEP),
                .FIG_WIDTH  (FIG_WIDTH),
                .FIG_HEIGHT (FIG_HEIGHT)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .clear     (!enable),
                .spawn     (spawn_vec[gi]),
                .step      (step_pulse),
                .collision (collision[gi]),
                .spawn_y   (spawn_y),
                .lcd_x     (lcd_x_reg),
                .lcd_y     (lcd_y_reg),
                .active    (active_vec[gi]),
                .hit       (hit_vec[gi])
            );
        end
    endgenerate

    // Scan position is registered once, the hit test is registered once more.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_x_reg <= '0;
            lcd_y_reg <= '0;
            valid_reg <= 1'b0;
            pixel_reg <= COLOR_BLACK;
        end else if (!enable) begin
            lcd_x_reg <= '0;
            lcd_y_reg <= '0;
            valid_reg <= 1'b0;
            pixel_reg <= COLOR_BLACK;
        end else begin
            lcd_x_reg <= lcd_xpos;
            lcd_y_reg <= lcd_ypos;
            valid_reg <= |hit_vec;
            pixel_reg <= (|hit_vec) ? COLOR : COLOR_BLACK;
        end
    end

    assign pixel_valid  = valid_reg;
    assign bullet_pixel = pixel_reg;
    assign slot_active  = active_vec;

endmodule
